// File: rtl/data_memory_ctrl.sv
// Load/store data memory: byte/halfword/word access with RISC-V funct3 semantics,
// one-cycle registered response, post-reset clear. Optional debug ILA: DMEM_ILA_EN.
module data_memory_ctrl #(
    parameter int ADDR_W         = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] byte_address,
    input  logic [31:0]       write_data,
    output logic              resp_valid,
    output logic [31:0]       read_data,
    output logic              resp_error,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // state    | meaning
    // ST_CLEAR | zeroing word[cnt_q] each cycle, requests ignored
    // ST_IDLE  | accepting one request per cycle
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      rd_word_q;
    logic             resp_valid_q, resp_error_q, ld_q;
    logic [2:0]       f3_q;
    logic [1:0]       lane_q;

    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic             legal, accept, store_en, load_en;
    logic [3:0]       be, wr_en;
    logic [31:0]      wdat, wr_dat, shifted, ext;
    logic [IDX_W-1:0] wr_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) state_d = ST_IDLE;
            end
            ST_IDLE: req_ready = 1'b1;
            default: state_d = RESET_STATE;
        endcase
    end

    assign lane = byte_address[1:0];
    assign idx  = byte_address[ADDR_W-1:2];

    // BU/HU have no store form, so they are only legal as loads
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~lane[0];
            3'b010:  legal = (lane == 2'b00);
            3'b100:  legal = ~req_write;
            3'b101:  legal = ~req_write & ~lane[0];
            default: legal = 1'b0;
        endcase
    end

    assign accept   = req_valid & req_ready & rst_n;
    assign store_en = accept & legal & req_write;
    assign load_en  = accept & legal & ~req_write;

    always_comb begin
        be = 4'b1111;
        case (req_funct3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
    end

    assign wdat   = write_data << {lane, 3'b000};
    assign wr_en  = busy ? 4'b1111 : (store_en ? be : 4'b0000);
    assign wr_idx = busy ? cnt_q : idx;
    assign wr_dat = busy ? 32'h0 : wdat;

    // Single write port plus read-first read, kept reset-free so it can map to block RAM
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en[b]) mem_q[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
        end
        rd_word_q <= mem_q[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            ld_q         <= 1'b0;
            f3_q         <= 3'b000;
            lane_q       <= 2'b00;
        end else begin
            resp_valid_q <= accept;
            resp_error_q <= accept & ~legal;
            ld_q         <= load_en;
            f3_q         <= req_funct3;
            lane_q       <= lane;
        end
    end

    assign shifted = rd_word_q >> {lane_q, 3'b000};

    always_comb begin
        ext = shifted;
        case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign read_data  = ld_q ? ext : 32'h0;

`ifdef DMEM_ILA_EN
    ila_dmem u_ila_dmem (
        .clk    (clk),
        .probe0 (mem_q[0]),
        .probe1 (mem_q[1]),
        .probe2 (mem_q[2]),
        .probe3 (mem_q[3]),
        .probe4 (mem_q[4]),
        .probe5 (mem_q[5]),
        .probe6 (mem_q[6]),
        .probe7 (mem_q[7]),
        .probe8 (mem_q[8]),
        .probe9 (mem_q[9]),
        .probe10(mem_q[10]),
        .probe11(mem_q[11]),
        .probe12(mem_q[12]),
        .probe13(mem_q[13]),
        .probe14(mem_q[14]),
        .probe15(mem_q[15]),
        .probe16(mem_q[16]),
        .probe17(mem_q[17]),
        .probe18(mem_q[18]),
        .probe19(mem_q[19]),
        .probe20({busy, resp_valid, resp_error})
    );
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl against a byte-addressed reference memory.
module tb_data_memory_ctrl;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [ADDR_W-1:0] byte_address = '0;
    logic [31:0]       write_data = 32'h0;
    logic              resp_valid;
    logic [31:0]       read_data;
    logic              resp_error;
    logic              busy;

    data_memory_ctrl #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_funct3  (req_funct3),
        .byte_address(byte_address),
        .write_data  (write_data),
        .resp_valid  (resp_valid),
        .read_data   (read_data),
        .resp_error  (resp_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  mdl [DEPTH*4];
    int          checks = 0;
    int          errors = 0;

    function automatic bit mdl_legal(bit w, logic [2:0] f3, int addr);
        case (f3)
            3'd0:    return 1'b1;
            3'd1:    return (addr % 2) == 0;
            3'd2:    return (addr % 4) == 0;
            3'd4:    return !w;
            3'd5:    return !w && ((addr % 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request at the current negedge; expectation follows the memory model.
    task automatic issue(input bit w, input logic [2:0] f3, input int addr, input logic [31:0] wd);
        exp_t        e;
        int          n;
        logic [31:0] v;
        req_valid    = 1'b1;
        req_write    = w;
        req_funct3   = f3;
        byte_address = addr[ADDR_W-1:0];
        write_data   = wd;
        if (req_ready === 1'b1 && rst_n === 1'b1) begin
            e.cyc  = cyc + 1;
            e.err  = 1'b0;
            e.data = 32'h0;
            if (!mdl_legal(w, f3, addr)) begin
                e.err = 1'b1;
            end else begin
                n = 1 << f3[1:0];
                if (w) begin
                    for (int i = 0; i < n; i++) mdl[addr + i] = wd[8*i +: 8];
                end else begin
                    v = 32'h0;
                    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[addr + i];
                    if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
                    if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
                    e.data = v;
                end
            end
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Hold reset for n cycles; outputs are checked after the first reset edge.
    task automatic do_reset(input int n, input string name);
        rst_n = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check({name, "_rst_resp_valid"}, {31'h0, resp_valid}, 32'h0);
        check({name, "_rst_read_data"}, read_data, 32'h0);
        check({name, "_rst_resp_error"}, {31'h0, resp_error}, 32'h0);
        check({name, "_rst_req_ready"}, {31'h0, req_ready}, 32'h0);
        check({name, "_rst_busy"}, {31'h0, busy}, 32'h1);
        repeat (n - 1) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Count busy cycles from reset release while firing requests that must be ignored.
    task automatic wait_clear(input string name);
        int n;
        bit ready_low;
        n = 0;
        ready_low = 1'b1;
        while (busy === 1'b1 && n < 1000) begin
            if (req_ready !== 1'b0) ready_low = 1'b0;
            req_valid    = 1'b1;
            req_write    = 1'b1;
            req_funct3   = 3'b010;
            byte_address = ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
            write_data   = $urandom;
            n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check({name, "_busy_cycles"}, n, 256);
        check({name, "_ready_low"}, {31'h0, ready_low}, 32'h1);
        check({name, "_ready_after"}, {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < DEPTH * 4; i++) mdl[i] = 8'h00;
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: cycle %0d err=%b data=%h with no request pending",
                         cyc, resp_error, read_data);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cyc != cyc || resp_error !== mon_e.err || read_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL resp: cycle %0d err=%b data=%h, expected cycle %0d err=%b data=%h",
                             cyc, resp_error, read_data, mon_e.cyc, mon_e.err, mon_e.data);
                end
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_resp: no resp_valid at cycle %0d, expected err=%b data=%h",
                     cyc, sb[0].err, sb[0].data);
            void'(sb.pop_front());
        end
    end

    initial begin
        @(negedge clk);
        do_reset(2, "init");
        wait_clear("clear0");

        for (int w = 0; w < DEPTH; w++) issue(1'b0, 3'b010, w * 4, 32'h0);
        idle(2);

        issue(1'b1, 3'b000, 'h013, 32'h0000_0080);
        issue(1'b0, 3'b010, 'h010, 32'h0);
        issue(1'b0, 3'b000, 'h013, 32'h0);
        issue(1'b0, 3'b100, 'h013, 32'h0);
        issue(1'b1, 3'b001, 'h012, 32'h0000_1234);
        issue(1'b0, 3'b010, 'h010, 32'h0);
        issue(1'b0, 3'b101, 'h012, 32'h0);
        idle(1);
        issue(1'b1, 3'b010, 'h010, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 'h010, 32'h0);
        idle(1);

        issue(1'b0, 3'b010, 'h011, 32'h0);
        issue(1'b1, 3'b001, 'h013, 32'h0000_5555);
        issue(1'b0, 3'b011, 'h010, 32'h0);
        issue(1'b1, 3'b100, 'h010, 32'h0000_00AA);
        issue(1'b1, 3'b111, 'h010, 32'hFFFF_FFFF);
        issue(1'b0, 3'b010, 'h010, 32'h0);
        idle(2);

        issue(1'b1, 3'b010, 'h020, 32'hCAFE_F00D);
        issue(1'b0, 3'b010, 'h020, 32'h0);
        issue(1'b0, 3'b000, 'h021, 32'h0);
        issue(1'b1, 3'b000, 'h022, 32'h0000_005A);
        issue(1'b0, 3'b010, 'h020, 32'h0);
        idle(2);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       int'($urandom_range(0, 63)), $urandom);
        end
        idle(3);

        issue(1'b1, 3'b010, 'h040, 32'h1122_3344);
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_funct3   = 3'b010;
        byte_address = ADDR_W'('h040);
        do_reset(2, "load_rst");
        wait_clear("clear_after_load_rst");
        issue(1'b0, 3'b010, 'h040, 32'h0);
        issue(1'b0, 3'b010, 'h010, 32'h0);
        idle(2);

        do_reset(2, "midclear_a");
        repeat (100) @(negedge clk);
        do_reset(1, "midclear_b");
        wait_clear("clear_restart");
        for (int k = 0; k < 16; k++) issue(1'b0, 3'b010, int'($urandom_range(0, DEPTH - 1)) * 4, 32'h0);
        issue(1'b0, 3'b010, 'h3FC, 32'h0);
        issue(1'b0, 3'b010, 'h000, 32'h0);
        idle(4);

        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
